prime_host_driver: RTL and testbench
====================================

Name: prime_host_driver

Overview:
- Host-side initiator for the prime detector's serial input interface. It accepts an nbits candidate over a val/rdy request port and serializes it MSB-first on SDI/SCLK/CS.
- It then toggles the level-sensitive ready line, waits for the detector's done, and returns is_prime on a val/rdy response port.
- Used as the on-board/FPGA test driver and in system benches in place of a manual user.

Parameters:
nbits, 32, candidate width; must match the detector
sclk_half, 8, clk cycles per SCLK half-period (≥2; sized to pass the detector's debouncer)
done_lo_max, 64, max clk cycles to wait for stale done to clear before proceeding anyway

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
req_val  in  1  request valid
req_rdy  out  1  request ready (high only in IDLE)
req_data  in  nbits  candidate number
resp_val  out  1  response valid
resp_rdy  in  1  response ready
resp_is_prime  out  1  captured result, stable while resp_val
SDI  out  1  serial data to detector
SCLK  out  1  serial clock to detector
CS  out  1  chip select, active low
ready  out  1  start line; toggles once per request
done_in  in  1  detector done (asynchronous; 2-flop synchronized internally)
is_prime_in  in  1  detector is_prime (sampled together with synchronized done)

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, SCLK=0, CS=1, SDI=0, ready=0, resp_val=0, resp_is_prime=0, counters=0, sync flops=0.
- IDLE: req_rdy=1. On req_val&&req_rdy, latch req_data into shift reg, set CS=0, SDI=req_data[nbits-1], go SHIFT.
- SHIFT: each bit is sclk_half cycles SCLK=0, then sclk_half cycles SCLK=1.
  - SDI changes only at the start of a low phase and is stable across the rising edge.
  - After bit 0's high phase, SCLK=0; go GAP.
  - Shift duration is exactly nbits*2*sclk_half cycles.
- GAP: CS stays 0 for sclk_half cycles, then CS=1, SDI=0; go TOGGLE.
- TOGGLE: ready <= ~ready (one cycle); go WAIT_LO.
- WAIT_LO: wait until done_sync==0 or done_lo_max cycles have elapsed, then go WAIT_HI.
- WAIT_HI: wait for done_sync==1 (no timeout). Capture is_prime_in, sampled through the same 2-flop delay as done, into resp_is_prime. Set resp_val=1, go RESP.
- RESP: hold resp_val and resp_is_prime until resp_val&&resp_rdy. Then resp_val=0, go IDLE; req_rdy rises the next cycle, so there is no same-cycle req/resp overlap.
- req_val while not IDLE: ignored, no effect.
- req_data is don't-care after the accept cycle.
- Reset mid-operation: immediate return to reset values.
  - CS rises and SCLK falls in the same cycle, aborting the partial frame.
  - ready returns to 0. If ready was 1, the detector sees one spurious toggle; the bench tolerates this.
- Outputs SDI, SCLK, CS and ready are registered (glitch-free).

Test Plan:
- nbits=8, sclk_half=2, req_data=8'hA5:
  - CS falls the cycle after accept.
  - SDI at the 8 SCLK rising edges = 1,0,1,0,0,1,0,1.
  - CS rises 2 cycles after the last falling edge.
  - ready toggles 0->1 exactly once.
- Detector model holds done=1 stale, drops it 3 cycles after the ready toggle, raises it 20 cycles later with is_prime=1 -> resp_val after the 2-cycle sync delay, resp_is_prime=1.
- Stale done never drops (model keeps done=1) -> WAIT_LO exits after done_lo_max=64 cycles; response returned with current is_prime_in.
- Hold resp_rdy=0 for 10 cycles:
  - resp_val and resp_is_prime stay constant; req_rdy stays 0.
  - After the handshake, req_rdy=1 the following cycle.
  - A second request toggles ready 1->0.
- reset=0 asserted on the 3rd SCLK high phase -> next cycle CS=1, SCLK=0, ready=0, req_rdy=1. A new request with 8'h07 returns is_prime=1 from the reference model.
- Full system loop with the detector, nbits=32: candidates 2, 97, 1_000_003, 91, 4294967291 -> is_prime = 1,1,1,0,1 in order.

Source files
------------

// File: rtl/prime_host_driver.sv
// Host-side driver for the prime detector: serializes a candidate MSB-first on SDI/SCLK/CS, toggles ready,
// then returns the synchronized is_prime result. Requests are accepted only in IDLE; the response is held until resp_rdy.
module prime_host_driver #(
    parameter int nbits       = 32,
    parameter int sclk_half   = 8,
    parameter int done_lo_max = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [nbits-1:0] req_data,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic             resp_is_prime,
    output logic             SDI,
    output logic             SCLK,
    output logic             CS,
    output logic             ready,
    input  logic             done_in,
    input  logic             is_prime_in
);
    localparam int PW = $clog2(sclk_half);
    localparam int BW = $clog2(nbits);
    localparam int WW = $clog2(done_lo_max + 1);
    localparam logic [PW-1:0] PH_LAST   = PW'(sclk_half - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(nbits - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(done_lo_max - 1);

    typedef enum logic [2:0] {IDLE, SHIFT, GAP, TOGGLE, WAIT_LO, WAIT_HI, RESP} state_t;

    state_t           state, state_nxt;
    logic [nbits-2:0] shreg, shreg_nxt;
    logic [PW-1:0]    ph_cnt, ph_cnt_nxt;
    logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
    logic [WW-1:0]    wait_cnt, wait_cnt_nxt;
    logic             sclk_nxt, cs_nxt, sdi_nxt, ready_nxt;
    logic             resp_val_nxt, resp_is_prime_nxt;
    logic [1:0]       done_sync, prime_sync;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            shreg         <= '0;
            ph_cnt        <= '0;
            bit_cnt       <= '0;
            wait_cnt      <= '0;
            SCLK          <= 1'b0;
            CS            <= 1'b1;
            SDI           <= 1'b0;
            ready         <= 1'b0;
            resp_val      <= 1'b0;
            resp_is_prime <= 1'b0;
            done_sync     <= '0;
            prime_sync    <= '0;
        end else begin
            state         <= state_nxt;
            shreg         <= shreg_nxt;
            ph_cnt        <= ph_cnt_nxt;
            bit_cnt       <= bit_cnt_nxt;
            wait_cnt      <= wait_cnt_nxt;
            SCLK          <= sclk_nxt;
            CS            <= cs_nxt;
            SDI           <= sdi_nxt;
            ready         <= ready_nxt;
            resp_val      <= resp_val_nxt;
            resp_is_prime <= resp_is_prime_nxt;
            // is_prime rides the same two-flop delay so it is aligned with done
            done_sync     <= {done_sync[0], done_in};
            prime_sync    <= {prime_sync[0], is_prime_in};
        end
    end

    always_comb begin
        state_nxt         = state;
        shreg_nxt         = shreg;
        ph_cnt_nxt        = ph_cnt;
        bit_cnt_nxt       = bit_cnt;
        wait_cnt_nxt      = wait_cnt;
        sclk_nxt          = SCLK;
        cs_nxt            = CS;
        sdi_nxt           = SDI;
        ready_nxt         = ready;
        resp_val_nxt      = resp_val;
        resp_is_prime_nxt = resp_is_prime;
        case (state)
            IDLE: begin
                if (req_val) begin
                    shreg_nxt   = req_data[nbits-2:0];
                    sdi_nxt     = req_data[nbits-1];
                    cs_nxt      = 1'b0;
                    ph_cnt_nxt  = '0;
                    bit_cnt_nxt = '0;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (ph_cnt == PH_LAST) begin
                    ph_cnt_nxt = '0;
                    if (!SCLK) begin
                        sclk_nxt = 1'b1;
                    end else begin
                        // falling edge: next bit goes out at the start of the low phase
                        sclk_nxt = 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            state_nxt = GAP;
                        end else begin
                            sdi_nxt     = shreg[nbits-2];
                            shreg_nxt   = shreg << 1;
                            bit_cnt_nxt = bit_cnt + 1'b1;
                        end
                    end
                end else begin
                    ph_cnt_nxt = ph_cnt + 1'b1;
                end
            end
            GAP: begin
                if (ph_cnt == PH_LAST) begin
                    ph_cnt_nxt = '0;
                    cs_nxt     = 1'b1;
                    sdi_nxt    = 1'b0;
                    state_nxt  = TOGGLE;
                end else begin
                    ph_cnt_nxt = ph_cnt + 1'b1;
                end
            end
            TOGGLE: begin
                ready_nxt    = ~ready;
                wait_cnt_nxt = '0;
                state_nxt    = WAIT_LO;
            end
            WAIT_LO: begin
                // a done left high from the previous run must clear first, but never stall forever
                if (!done_sync[1] || wait_cnt == WAIT_LAST) begin
                    state_nxt = WAIT_HI;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            WAIT_HI: begin
                if (done_sync[1]) begin
                    resp_is_prime_nxt = prime_sync[1];
                    resp_val_nxt      = 1'b1;
                    state_nxt         = RESP;
                end
            end
            RESP: begin
                if (resp_rdy) begin
                    resp_val_nxt = 1'b0;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req_rdy = (state == IDLE);

endmodule

// File: tb/tb_prime_host_driver.sv
// Directed bench for prime_host_driver: an 8-bit instance with hand-driven detector lines and a
// 32-bit instance looped through a behavioural detector.
module tb_prime_host_driver;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic       req_val8, req_rdy8, resp_val8, resp_rdy8, resp_prime8;
    logic [7:0] req_data8, cap8;
    logic       sdi8, sclk8, cs8, ready8, done8, prime8;

    logic        req_val32, req_rdy32, resp_val32, resp_rdy32, resp_prime32;
    logic [31:0] req_data32, cap32;
    logic        sdi32, sclk32, cs32, ready32, done32, prime32;

    prime_host_driver #(.nbits(8), .sclk_half(2), .done_lo_max(64)) dut8 (
        .clk(clk), .reset(reset),
        .req_val(req_val8), .req_rdy(req_rdy8), .req_data(req_data8),
        .resp_val(resp_val8), .resp_rdy(resp_rdy8), .resp_is_prime(resp_prime8),
        .SDI(sdi8), .SCLK(sclk8), .CS(cs8), .ready(ready8),
        .done_in(done8), .is_prime_in(prime8)
    );

    prime_host_driver #(.nbits(32), .sclk_half(2), .done_lo_max(64)) dut32 (
        .clk(clk), .reset(reset),
        .req_val(req_val32), .req_rdy(req_rdy32), .req_data(req_data32),
        .resp_val(resp_val32), .resp_rdy(resp_rdy32), .resp_is_prime(resp_prime32),
        .SDI(sdi32), .SCLK(sclk32), .CS(cs32), .ready(ready32),
        .done_in(done32), .is_prime_in(prime32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Detector-side deserializers: sample SDI on each SCLK rising edge while selected
    always @(posedge sclk8)  if (!cs8)  cap8  <= {cap8[6:0], sdi8};
    always @(posedge sclk32) if (!cs32) cap32 <= {cap32[30:0], sdi32};

    function automatic logic is_prime_f(input longint n);
        if (n < 2) return 1'b0;
        for (longint d = 2; d * d <= n; d++)
            if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(2);
        checks++; if (cs8 !== 1'b1) begin errors++; $display("FAIL reset_cs got=%b exp=1", cs8); end
        checks++; if (sclk8 !== 1'b0) begin errors++; $display("FAIL reset_sclk got=%b exp=0", sclk8); end
        checks++; if (sdi8 !== 1'b0) begin errors++; $display("FAIL reset_sdi got=%b exp=0", sdi8); end
        checks++; if (ready8 !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready8); end
        checks++; if (resp_val8 !== 1'b0 || resp_prime8 !== 1'b0)
            begin errors++; $display("FAIL reset_resp got=%b%b exp=00", resp_val8, resp_prime8); end
        checks++; if (req_rdy8 !== 1'b1 || req_rdy32 !== 1'b1)
            begin errors++; $display("FAIL reset_req_rdy got=%b%b exp=11", req_rdy8, req_rdy32); end
        reset = 1'b1;
        tick(1);
    endtask

    task automatic test_serialize();
        int   last_fall, cs_rise, rises, toggles;
        logic p_sclk, p_cs, p_ready;
        last_fall = -1; cs_rise = -1; rises = 0; toggles = 0;
        prime8    = 1'b0;
        req_val8  = 1'b1;
        req_data8 = 8'hA5;
        checks++; if (cs8 !== 1'b1) begin errors++; $display("FAIL pre_accept_cs got=%b exp=1", cs8); end
        tick(1);
        req_val8  = 1'b0;
        req_data8 = 8'h00;
        checks++; if (cs8 !== 1'b0) begin errors++; $display("FAIL cs_fall got=%b exp=0", cs8); end
        p_sclk = sclk8; p_cs = cs8; p_ready = ready8;
        for (int c = 1; c <= 38; c++) begin
            tick(1);
            if (p_sclk && !sclk8) last_fall = c;
            if (!p_sclk && sclk8) rises++;
            if (!p_cs && cs8 && cs_rise < 0) cs_rise = c;
            if (p_ready !== ready8) toggles++;
            p_sclk = sclk8; p_cs = cs8; p_ready = ready8;
        end
        checks++; if (cap8 !== 8'hA5) begin errors++; $display("FAIL sdi_bits got=%h exp=a5", cap8); end
        checks++; if (rises != 8) begin errors++; $display("FAIL sclk_rises got=%0d exp=8", rises); end
        checks++; if (last_fall != 32) begin errors++; $display("FAIL shift_len got=%0d exp=32", last_fall); end
        checks++; if (cs_rise - last_fall != 2)
            begin errors++; $display("FAIL cs_gap got=%0d exp=2", cs_rise - last_fall); end
        checks++; if (toggles != 1 || ready8 !== 1'b1)
            begin errors++; $display("FAIL ready_toggle got=%0d/%b exp=1/1", toggles, ready8); end
        // stale done clears 3 cycles after the toggle, real done 20 cycles later
        done8 = 1'b0;
        tick(20);
        prime8 = 1'b1;
        done8  = 1'b1;
        tick(2);
        checks++; if (resp_val8 !== 1'b0) begin errors++; $display("FAIL resp_early got=%b exp=0", resp_val8); end
        tick(1);
        checks++; if (resp_val8 !== 1'b1 || resp_prime8 !== 1'b1)
            begin errors++; $display("FAIL resp_sync got=%b%b exp=11", resp_val8, resp_prime8); end
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        resp_rdy8 = 1'b0;
        prime8    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checks++;
            if (resp_val8 !== 1'b1 || resp_prime8 !== 1'b1 || req_rdy8 !== 1'b0) begin
                errors++;
                $display("FAIL hold_resp cyc=%0d got=%b%b%b exp=110", i, resp_val8, resp_prime8, req_rdy8);
            end
        end
        resp_rdy8 = 1'b1;
        tick(1);
        resp_rdy8 = 1'b0;
        checks++; if (resp_val8 !== 1'b0 || req_rdy8 !== 1'b1)
            begin errors++; $display("FAIL handshake got=%b%b exp=01", resp_val8, req_rdy8); end
    endtask

    task automatic test_stale_timeout();
        int i;
        prime8    = 1'b0;
        req_val8  = 1'b1;
        req_data8 = 8'h3C;
        tick(1);
        // requests while busy must be ignored
        req_data8 = 8'hFF;
        for (i = 0; i < 100 && ready8 === 1'b1; i++) tick(1);
        req_val8 = 1'b0;
        checks++; if (ready8 !== 1'b0) begin errors++; $display("FAIL ready_second got=%b exp=0", ready8); end
        checks++; if (cap8 !== 8'h3C) begin errors++; $display("FAIL busy_ignore got=%h exp=3c", cap8); end
        tick(64);
        checks++; if (resp_val8 !== 1'b0) begin errors++; $display("FAIL lo_timeout_early got=%b exp=0", resp_val8); end
        tick(1);
        checks++; if (resp_val8 !== 1'b1 || resp_prime8 !== 1'b0)
            begin errors++; $display("FAIL lo_timeout got=%b%b exp=10", resp_val8, resp_prime8); end
        resp_rdy8 = 1'b1;
        tick(1);
        resp_rdy8 = 1'b0;
    endtask

    task automatic test_reset_mid();
        int   rises, i;
        logic p_sclk;
        rises = 0;
        req_val8  = 1'b1;
        req_data8 = 8'h07;
        tick(1);
        req_val8 = 1'b0;
        p_sclk = sclk8;
        for (i = 0; i < 40 && rises < 3; i++) begin
            tick(1);
            if (!p_sclk && sclk8) rises++;
            p_sclk = sclk8;
        end
        reset = 1'b0;
        tick(1);
        checks++; if (cs8 !== 1'b1 || sclk8 !== 1'b0 || ready8 !== 1'b0 || req_rdy8 !== 1'b1)
            begin errors++; $display("FAIL abort got=%b%b%b%b exp=1001", cs8, sclk8, ready8, req_rdy8); end
        reset = 1'b1;
        tick(1);
        req_val8  = 1'b1;
        req_data8 = 8'h07;
        tick(1);
        req_val8 = 1'b0;
        for (i = 0; i < 100 && ready8 === 1'b0; i++) tick(1);
        checks++; if (ready8 !== 1'b1) begin errors++; $display("FAIL retry_toggle got=%b exp=1", ready8); end
        tick(3);
        done8 = 1'b0;
        tick(20);
        prime8 = is_prime_f(longint'(cap8));
        done8  = 1'b1;
        for (i = 0; i < 20 && resp_val8 !== 1'b1; i++) tick(1);
        checks++; if (resp_val8 !== 1'b1 || resp_prime8 !== 1'b1 || cap8 !== 8'h07)
            begin errors++; $display("FAIL retry_07 got=%b%b/%h exp=11/07", resp_val8, resp_prime8, cap8); end
        resp_rdy8 = 1'b1;
        tick(1);
        resp_rdy8 = 1'b0;
    endtask

    task automatic test_system();
        logic [31:0] cands [5] = '{32'd2, 32'd97, 32'd1000003, 32'd91, 32'd4294967291};
        logic        expect_p [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 5; k++) begin
            logic r0;
            int   i;
            req_val32  = 1'b1;
            req_data32 = cands[k];
            tick(1);
            req_val32 = 1'b0;
            r0 = ready32;
            for (i = 0; i < 400 && ready32 === r0; i++) tick(1);
            checks++; if (ready32 === r0) begin errors++; $display("FAIL sys_toggle k=%0d got=%b", k, ready32); end
            tick(3);
            done32 = 1'b0;
            tick(20);
            prime32 = is_prime_f(longint'(cap32));
            done32  = 1'b1;
            for (i = 0; i < 20 && resp_val32 !== 1'b1; i++) tick(1);
            checks++; if (cap32 !== cands[k])
                begin errors++; $display("FAIL sys_frame k=%0d got=%0d exp=%0d", k, cap32, cands[k]); end
            checks++; if (resp_val32 !== 1'b1 || resp_prime32 !== expect_p[k])
                begin errors++; $display("FAIL sys_prime k=%0d got=%b%b exp=1%b", k, resp_val32, resp_prime32, expect_p[k]); end
            resp_rdy32 = 1'b1;
            tick(1);
            resp_rdy32 = 1'b0;
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0;
        req_val8 = 1'b0; req_data8 = 8'h00; resp_rdy8 = 1'b0; done8 = 1'b1; prime8 = 1'b0;
        req_val32 = 1'b0; req_data32 = 32'h0; resp_rdy32 = 1'b0; done32 = 1'b1; prime32 = 1'b0;
        test_reset();
        test_serialize();
        test_backpressure();
        test_stale_timeout();
        test_reset_mid();
        test_system();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
